// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the sequential FPU blocks.
//   fp32_t       : IEEE-754 single-precision field view
//   FP_QNAN      : canonical quiet NaN returned for invalid operations
//   EXP_MAX      : all-ones exponent (inf / NaN)
//   state_t      : control states of the sequential subtractor
//   pack_result  : encodes sign / exponent / normalised 25-bit mantissa
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] FP_QNAN = 32'h7FC00000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ARITH = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Final encoding of a normalised mantissa. A zero mantissa is always +0,
  // an all-ones exponent collapses to infinity, and exp==1 without the
  // hidden bit is a denormal (encoded exponent 0).
  function automatic logic [31:0] pack_result(input logic        sign,
                                              input logic [7:0]  exp,
                                              input logic [24:0] m);
    logic [31:0] r;
    if (m == 25'd0)
      r = 32'h0;
    else if (exp == EXP_MAX)
      r = {sign, EXP_MAX, 23'h0};
    else if (exp == 8'd1 && !m[23])
      r = {sign, 8'h00, m[22:0]};
    else
      r = {sign, exp, m[22:0]};
    return r;
  endfunction

endpackage

// File: rtl/fp_norm_step.sv
// Single-step mantissa normaliser, purely combinational.
//   m        : 25-bit working mantissa (bit 24 = carry, bit 23 = hidden bit)
//   exp      : current exponent
//   m_next   : mantissa after one step
//   exp_next : exponent after one step
//   done     : no further step is needed; m/exp are passed through unchanged
// A carry is absorbed with one right shift; otherwise one left shift per call
// until the hidden bit is set, the mantissa is zero, or exp bottoms out at 1.
module fp_norm_step (
  input  logic [24:0] m,
  input  logic [7:0]  exp,
  output logic [24:0] m_next,
  output logic [7:0]  exp_next,
  output logic        done
);

  always_comb begin
    m_next   = m;
    exp_next = exp;
    done     = 1'b0;
    if (m[24]) begin
      m_next   = m >> 1;
      exp_next = exp + 8'd1;
    end else if (!m[23] && (m != 25'd0) && (exp > 8'd1)) begin
      m_next   = m << 1;
      exp_next = exp - 8'd1;
    end else begin
      done = 1'b1;
    end
  end

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor: out = a - b.
// Alignment and normalisation move one bit per cycle, so there is no barrel
// shifter. Shifted-out bits are truncated.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake, in_ready high only in IDLE
//   a, b                : minuend / subtrahend
//   out_valid/out_ready : result handshake, out held until accepted
//   out                 : a - b
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid, once raised by the producer, holds with its data until
// that edge.
module fp_sub_seq
  import fp_pkg::*;
#(
  parameter int unsigned MAX_ALIGN = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
);

  localparam int CNT_W = $clog2(MAX_ALIGN + 1);

  state_t state, state_next;

  fp32_t fa, fb;
  assign fa = a;
  assign fb = b;

  logic        a_nan, b_nan, a_inf, b_inf, special;
  logic [31:0] special_val;
  logic        accept;

  // Working registers; b is held with its sign already inverted so the
  // datapath is a pure addition of signed magnitudes.
  logic             sign_a, sign_b, sign_r;
  logic [7:0]       exp_a, exp_b;
  logic [23:0]      man_a, man_b;
  logic [24:0]      man_r;
  logic [CNT_W-1:0] shift_cnt;

  logic        exps_equal, a_smaller, cap_hit;
  logic [24:0] norm_m;
  logic [7:0]  norm_exp;
  logic        norm_done;

  assign accept     = in_valid && in_ready;
  assign exps_equal = (exp_a == exp_b);
  assign a_smaller  = (exp_a < exp_b);
  assign cap_hit    = (shift_cnt == CNT_W'(MAX_ALIGN));

  // Special operands bypass the datapath entirely.
  always_comb begin
    a_nan   = (fa.exp == EXP_MAX) && (fa.frac != 23'd0);
    b_nan   = (fb.exp == EXP_MAX) && (fb.frac != 23'd0);
    a_inf   = (fa.exp == EXP_MAX) && (fa.frac == 23'd0);
    b_inf   = (fb.exp == EXP_MAX) && (fb.frac == 23'd0);
    special = a_nan || b_nan || a_inf || b_inf;
    if (a_nan || b_nan)
      special_val = FP_QNAN;
    else if (a_inf && b_inf && (fa.sign == fb.sign))
      special_val = FP_QNAN;
    else if (a_inf)
      special_val = a;
    else
      special_val = {~b[31], b[30:0]};
  end

  fp_norm_step u_norm (
    .m        (man_r),
    .exp      (exp_a),
    .m_next   (norm_m),
    .exp_next (norm_exp),
    .done     (norm_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic. ALIGN spends one extra cycle recognising that the
  // exponents match (or that the cap was hit), and NORM one extra cycle
  // recognising that the mantissa is normalised.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = special ? DONE : ALIGN;
      ALIGN:   if (exps_equal || cap_hit) state_next = ARITH;
      ARITH:   state_next = NORM;
      NORM:    if (norm_done) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      sign_r    <= 1'b0;
      exp_a     <= 8'd0;
      exp_b     <= 8'd0;
      man_a     <= 24'd0;
      man_b     <= 24'd0;
      man_r     <= 25'd0;
      shift_cnt <= '0;
      out       <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (special) begin
              out <= special_val;
            end else begin
              // Denormals use exponent 1 with a clear hidden bit.
              sign_a    <= fa.sign;
              sign_b    <= ~fb.sign;
              exp_a     <= (fa.exp == 8'd0) ? 8'd1 : fa.exp;
              exp_b     <= (fb.exp == 8'd0) ? 8'd1 : fb.exp;
              man_a     <= {(fa.exp != 8'd0), fa.frac};
              man_b     <= {(fb.exp != 8'd0), fb.frac};
              shift_cnt <= '0;
            end
          end
        end
        ALIGN: begin
          if (!exps_equal) begin
            if (cap_hit) begin
              if (a_smaller) begin
                man_a <= 24'd0;
                exp_a <= exp_b;
              end else begin
                man_b <= 24'd0;
                exp_b <= exp_a;
              end
            end else begin
              if (a_smaller) begin
                man_a <= man_a >> 1;
                exp_a <= exp_a + 8'd1;
              end else begin
                man_b <= man_b >> 1;
                exp_b <= exp_b + 8'd1;
              end
              shift_cnt <= shift_cnt + CNT_W'(1);
            end
          end
        end
        ARITH: begin
          if (sign_a == sign_b) begin
            man_r  <= {1'b0, man_a} + {1'b0, man_b};
            sign_r <= sign_a;
          end else if (man_a >= man_b) begin
            man_r  <= {1'b0, man_a - man_b};
            sign_r <= sign_a;
          end else begin
            man_r  <= {1'b0, man_b - man_a};
            sign_r <= sign_b;
          end
        end
        NORM: begin
          if (norm_done) begin
            out <= pack_result(sign_r, exp_a, man_r);
          end else begin
            man_r <= norm_m;
            exp_a <= norm_exp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Randomised bench for fp_sub_seq: directed corner cases, then random
// operands checked against a plain-arithmetic reference of a - b with
// truncating alignment, including the expected accept-to-valid latency.
module tb_fp_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  fp_sub_seq #(.MAX_ALIGN(26)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Reference model: a - b from the arithmetic rules, with latency.
  task automatic model_sub(input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] res, output int lat);
    logic   sx, sy, sr, x_nan, y_nan, x_inf, y_inf;
    int     ex, ey, e, d, k, n;
    longint mx, my, v, mag;
    x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (x_nan || y_nan || x_inf || y_inf) begin
      lat = 1;
      if (x_nan || y_nan)                    res = 32'h7FC00000;
      else if (x_inf && y_inf && x[31] == y[31]) res = 32'h7FC00000;
      else if (x_inf)                        res = x;
      else                                   res = y ^ 32'h80000000;
      return;
    end
    sx = x[31];
    sy = ~y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]) + ((ex == 0) ? 64'd0 : 64'd8388608);
    my = longint'(y[22:0]) + ((ey == 0) ? 64'd0 : 64'd8388608);
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    if (ex >= ey) begin
      d = ex - ey; e = ex;
      my = (d > 26) ? 64'd0 : (my >> d);
    end else begin
      d = ey - ex; e = ey;
      mx = (d > 26) ? 64'd0 : (mx >> d);
    end
    k = (d > 26) ? 26 : d;
    v = (sx ? -mx : mx) + (sy ? -my : my);
    sr  = (v < 0);
    mag = sr ? -v : v;
    n = 0;
    if (mag == 0) begin
      res = 32'h0;
    end else begin
      if (mag >= 64'd16777216) begin
        mag = mag >> 1; e = e + 1; n = 1;
      end else begin
        while (mag < 64'd8388608 && e > 1) begin
          mag = mag << 1; e = e - 1; n = n + 1;
        end
      end
      if (e >= 255)             res = {sr, 8'hFF, 23'h0};
      else if (mag < 64'd8388608) res = {sr, 8'h00, mag[22:0]};
      else                      res = {sr, 8'(e), mag[22:0]};
    end
    lat = 3 + k + n;
  endtask

  // Driver: one complete transaction, with the result held for `hold`
  // cycles before it is accepted.
  task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                       input logic [31:0] e_out, input int e_lat, input int hold);
    int          cyc;
    logic [31:0] held;
    exp_q.push_back(e_out);
    lat_q.push_back(e_lat);
    @(negedge clk);
    a = op_a; b = op_b; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      if (out_valid) break;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'(out_valid), 32'd1);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    check("out", out, exp_q.pop_front());
    check("latency", 32'(cyc), 32'(lat_q.pop_front()));
    held = out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out", out, held);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic gen_operands(output logic [31:0] x, output logic [31:0] y);
    int ex, ey;
    x = $urandom;
    y = $urandom;
    case ($urandom_range(0, 8))
      0: ;
      1, 2, 3: begin
        ex = $urandom_range(1, 254);
        ey = ex + $urandom_range(0, 6) - 3;
        if (ey < 1) ey = 1;
        if (ey > 254) ey = 254;
        x[30:23] = 8'(ex);
        y[30:23] = 8'(ey);
      end
      4: begin
        x[30:23] = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
        y[30:23] = 8'd0;
      end
      5: begin
        x[30:23] = 8'($urandom_range(1, 254));
        y[30:23] = 8'($urandom_range(1, 254));
      end
      6: begin
        case ($urandom_range(0, 3))
          0: x = 32'h7F800000;
          1: x = 32'hFF800000;
          2: y = 32'h7F800000 | {$urandom_range(0, 1) == 1, 31'h0};
          default: y = 32'h7F800001 + 32'($urandom_range(0, 1000));
        endcase
      end
      7: begin
        x[30:23] = 8'($urandom_range(1, 254));
        y = ($urandom_range(0, 1) == 0) ? x : (x ^ 32'h80000000);
      end
      default: begin
        x[30:23] = 8'd254;
        y[30:23] = 8'($urandom_range(252, 254));
      end
    endcase
  endtask

  initial begin
    logic [31:0] ra, rb, r_exp;
    int          r_lat, seen;

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, 0);
    do_op(32'h3F800000, 32'h3F800000, 32'h00000000, 3, 1);
    do_op(32'h3F800000, 32'hBF800000, 32'h40000000, 4, 0);
    do_op(32'h3F800000, 32'h33800000, 32'h3F800000, 27, 0);
    do_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0);
    do_op(32'h7FC00001, 32'h00000000, 32'h7FC00000, 1, 0);
    do_op(32'h7F800000, 32'hFF800000, 32'h7F800000, 1, 0);
    do_op(32'h3F800000, 32'hFF800000, 32'h7F800000, 1, 0);
    do_op(32'h40400000, 32'h3F800000, 32'h40000000, 4, 5);
    do_op(32'h00000003, 32'h00000001, 32'h00000002, 3, 0);
    do_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, 0);
    do_op(32'h3F800000, 32'h30000000, 32'h3F800000, 29, 0);

    // Reset in the middle of alignment abandons the operation
    @(negedge clk);
    a = 32'h3F800000; b = 32'h33800000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out", out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midreset_no_output", 32'(seen), 32'd0);

    // Random operands against the reference model
    for (int i = 0; i < 300; i++) begin
      gen_operands(ra, rb);
      model_sub(ra, rb, r_exp, r_lat);
      do_op(ra, rb, r_exp, r_lat, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
